// File: rtl/pio_out_handshake.sv
// rtl/pio_out_handshake.sv - Avalon-MM write-side PIO with shadow register and valid/ack launch
// Optional feature macro: PIO_OUT_HANDSHAKE_IRQ_EN (done flag, irq enable, irq output)
module pio_out_handshake #(
    parameter int                    DATA_WIDTH  = 27,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
`ifdef PIO_OUT_HANDSHAKE_IRQ_EN
    output logic                  irq,
`endif
    input  logic                  out_ack
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shadow, shadow_next;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    pending, pending_next;
    logic                    overflow, overflow_next;
    logic                    autocommit;
    logic                    wr, commit, handshake, load, ovf_set, ovf_clr;
    logic [31:0]             rd_next;
    logic                    done, irq_en;
    wire                     unused_wd = &{1'b0, writedata};

    assign wdata     = writedata[DATA_WIDTH-1:0];
    assign wr        = chipselect && !write_n;
    assign out_valid = (state == BUSY);
    assign handshake = (state == BUSY) && out_ack;
    assign ovf_clr   = wr && (address == 3'd1) && writedata[1];
    assign commit    = (wr && (address == 3'd1) && writedata[0]) ||
                       (wr && autocommit && (address == 3'd0 || address == 3'd4 || address == 3'd5));

    always_comb begin
        shadow_next = shadow;
        if (wr) begin
            case (address)
                3'd0:    shadow_next = wdata;
                3'd4:    shadow_next = shadow | wdata;
                3'd5:    shadow_next = shadow & ~wdata;
                default: shadow_next = shadow;
            endcase
        end
    end

    // A commit landing on the handshake cycle behaves like a pending commit: back-to-back launch.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        load         = 1'b0;
        ovf_set      = 1'b0;
        unique case (state)
            IDLE: begin
                if (commit) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (out_ack) begin
                    if (pending || commit) begin
                        load         = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (commit) begin
                    ovf_set      = pending;
                    pending_next = 1'b1;
                end
            end
        endcase
        overflow_next = (overflow && !ovf_clr) || ovf_set;
    end

    always_comb begin
        rd_next = 32'd0;
        case (address)
            3'd0:    rd_next = 32'(shadow);
            3'd1:    rd_next = {28'd0, done, pending, overflow, out_valid};
            3'd2:    rd_next = {30'd0, irq_en, autocommit};
            3'd3:    rd_next = 32'(out_port);
            default: rd_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= RESET_VALUE;
            out_port   <= RESET_VALUE;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            autocommit <= 1'b0;
            readdata   <= 32'd0;
        end else begin
            shadow   <= shadow_next;
            pending  <= pending_next;
            overflow <= overflow_next;
            readdata <= rd_next;
            if (load)
                out_port <= shadow_next;
            if (wr && address == 3'd2)
                autocommit <= writedata[0];
        end
    end

`ifdef PIO_OUT_HANDSHAKE_IRQ_EN
    logic irq_q;

    // Set beats clear when a handshake and a CTRL bit2 write coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done   <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (handshake)
                done <= 1'b1;
            else if (wr && address == 3'd1 && writedata[2])
                done <= 1'b0;
            if (wr && address == 3'd2)
                irq_en <= writedata[1];
            irq_q <= done && irq_en;
        end
    end

    assign irq = irq_q;
`else
    assign done   = 1'b0;
    assign irq_en = 1'b0;
    wire unused_hs = handshake;
`endif

endmodule
